// File: rtl/note_duration_timer.sv
// rtl/note_duration_timer.sv - note length sequencer: waits for song store, plays N ticks, trailing gap, pulses note_change.
// Optional tempo input enabled by defining NOTE_TIMER_TEMPO_EN. READ_LAT must be at least 1.
module note_duration_timer #(
  parameter int unsigned TICK_DIV  = 1562500,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] length,
`ifdef NOTE_TIMER_TEMPO_EN
  input  logic [1:0] tempo,
`endif
  output logic       note_change,
  output logic       mute,
  output logic       busy
);

`ifdef NOTE_TIMER_TEMPO_EN
  localparam int unsigned MAX_DIV = TICK_DIV * 4;
`else
  localparam int unsigned MAX_DIV = TICK_DIV;
`endif
  localparam int DW = $clog2(MAX_DIV + 1);
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] presc;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_sel;
  logic [4:0]    remaining;
  logic [4:0]    rem_dec;
  logic [WW-1:0] wait_cnt;
  logic          timing;
  logic          tick;
  logic          last_tick;
  logic          enter_gap;

`ifdef NOTE_TIMER_TEMPO_EN
  always_comb begin
    div_sel = DW'(TICK_DIV);
    case (tempo)
      2'b01:   div_sel = DW'(TICK_DIV / 2);
      2'b10:   div_sel = DW'(TICK_DIV * 2);
      2'b11:   div_sel = DW'(TICK_DIV * 4);
      default: div_sel = DW'(TICK_DIV);
    endcase
  end
`else
  assign div_sel = DW'(TICK_DIV);
`endif

  assign timing    = (state == S_PLAY) || (state == S_GAP);
  assign tick      = timing && (presc == div_q - DW'(1));
  assign rem_dec   = (remaining != 5'd0) ? remaining - 5'd1 : 5'd0;
  assign last_tick = tick && (remaining == 5'd1);
  // Gap starts on the tick that leaves exactly GAP_TICKS ticks to go.
  assign enter_gap = (GAP_TICKS > 0) && (state == S_PLAY) && tick &&
                     (32'(rem_dec) == GAP_TICKS);

  assign note_change = last_tick && enable;
  assign mute        = (state == S_IDLE) || (state == S_GAP);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      div_q     <= DW'(TICK_DIV);
    end else if (!enable) begin
      state     <= S_IDLE;
      presc     <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == WW'(READ_LAT - 1)) state <= S_LOAD;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        S_LOAD: begin
          remaining <= (length == 4'd0) ? 5'd16 : {1'b0, length};
          presc     <= '0;
          div_q     <= div_sel;
          wait_cnt  <= '0;
          state     <= S_PLAY;
        end
        S_PLAY, S_GAP: begin
          if (tick) begin
            presc     <= '0;
            remaining <= rem_dec;
            if (last_tick) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end else if (enter_gap) begin
              state <= S_GAP;
            end
          end else begin
            presc <= presc + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_duration_timer.sv
// tb/tb_note_duration_timer.sv - self-checking bench for note_duration_timer against a schedule-based reference model.
module tb_note_duration_timer;
  localparam int TD = 4;
  localparam int GT = 1;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] length;
  logic [1:0] tempo;
  logic       note_change;
  logic       mute;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  bit run = 0;
  int load_at = 0;
  int n_cur = 1;
  int d_cur = TD;
  bit exp_nc, exp_mute, exp_busy;
  bit obs_nc, obs_mute, obs_busy;
  int obs_cyc;

  note_duration_timer #(.TICK_DIV(TD), .GAP_TICKS(GT), .READ_LAT(RL)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .length(length),
`ifdef NOTE_TIMER_TEMPO_EN
    .tempo(tempo),
`endif
    .note_change(note_change),
    .mute(mute),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int eff_div(input logic [1:0] tp);
`ifdef NOTE_TIMER_TEMPO_EN
    case (tp)
      2'b01:   return TD / 2;
      2'b10:   return TD * 2;
      2'b11:   return TD * 4;
      default: return TD;
    endcase
`else
    return (tp === 2'bxx) ? 0 : TD;
`endif
  endfunction

  // Drives one cycle of inputs, samples DUT at negedge and advances the reference schedule.
  task automatic tick_cycle(input bit en, input bit r, input logic [3:0] len, input logic [1:0] tp);
    int off;
    enable = en; rst = r; length = len; tempo = tp;
    @(negedge clk);
    obs_nc = note_change; obs_mute = mute; obs_busy = busy; obs_cyc = cyc;
    if (r) begin
      run = 0; exp_nc = 0; exp_mute = 1; exp_busy = 0;
    end else if (!run) begin
      exp_nc = 0; exp_mute = 1; exp_busy = 0;
      if (en) begin run = 1; load_at = cyc + RL + 1; end
    end else if (cyc <= load_at) begin
      exp_nc = 0; exp_mute = 0; exp_busy = 1;
      if (cyc == load_at) begin
        n_cur = (len == 4'd0) ? 16 : int'(len);
        d_cur = eff_div(tp);
      end
      if (!en) run = 0;
    end else begin
      off = cyc - load_at;
      exp_busy = 1;
      exp_nc = (off == n_cur * d_cur) && en;
      exp_mute = (n_cur > GT) && (GT > 0) && (off > (n_cur - GT) * d_cur);
      if (!en) run = 0;
      else if (off == n_cur * d_cur) load_at = cyc + RL + 1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 3; i++) tick_cycle(0, 0, 4'd0, 2'b00);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick_cycle(1, 1, 4'd3, 2'b00);
      checks++;
      if ({obs_nc, obs_mute, obs_busy} !== 3'b010) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got nc/mute/busy=%b%b%b exp=010", obs_cyc, obs_nc, obs_mute, obs_busy);
      end
    end
    go_idle();
    for (int i = 0; i < 8; i++) tick_cycle(1, 0, 4'd3, 2'b00);
    tick_cycle(0, 1, 4'd3, 2'b00);
    checks++;
    if ({obs_nc, obs_mute, obs_busy} !== 3'b010) begin
      failures++;
      $display("FAIL reset_mid_play got nc/mute/busy=%b%b%b exp=010", obs_nc, obs_mute, obs_busy);
    end
    begin
      int pulses = 0;
      for (int i = 0; i < 40; i++) begin
        tick_cycle(0, 0, 4'd3, 2'b00);
        if (obs_nc || obs_busy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
        failures++;
        $display("FAIL reset_no_pulse got active_cycles=%0d exp=0", pulses);
      end
    end
  endtask

  task automatic run_fixed(input string name, input logic [3:0] len, input logic [1:0] tp,
                           input int ncyc, input int first_lat, input int period);
    int pq[$];
    int start;
    start = cyc;
    for (int i = 0; i < ncyc; i++) begin
      tick_cycle(1, 0, len, tp);
      checks++;
      if ({obs_nc, obs_mute, obs_busy} !== {exp_nc, exp_mute, exp_busy}) begin
        failures++;
        $display("FAIL %s cyc=%0d got nc/mute/busy=%b%b%b exp=%b%b%b", name, obs_cyc,
                 obs_nc, obs_mute, obs_busy, exp_nc, exp_mute, exp_busy);
      end
      if (obs_nc) pq.push_back(obs_cyc);
    end
    checks++;
    if (pq.size() < 2) begin
      failures++;
      $display("FAIL %s_pulse_count got=%0d exp>=2", name, pq.size());
    end else begin
      checks++;
      if (pq[0] - (start + RL + 1) !== first_lat) begin
        failures++;
        $display("FAIL %s_first_latency got=%0d exp=%0d", name, pq[0] - (start + RL + 1), first_lat);
      end
      for (int i = 1; i < pq.size(); i++) begin
        checks++;
        if (pq[i] - pq[i-1] !== period) begin
          failures++;
          $display("FAIL %s_period got=%0d exp=%0d", name, pq[i] - pq[i-1], period);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_basic();      run_fixed("basic", 4'd3, 2'b00, 50, 12, 15);   endtask
  task automatic test_zero_length(); run_fixed("zero_len", 4'd0, 2'b00, 210, 64, 67); endtask
  task automatic test_no_gap();     run_fixed("no_gap", 4'd1, 2'b00, 30, 4, 7);     endtask

  task automatic test_enable_drop();
    int start;
    int pulse_at;
    start = cyc;
    for (int i = 0; i < 15; i++) tick_cycle(1, 0, 4'd3, 2'b00);
    tick_cycle(0, 0, 4'd3, 2'b00);
    checks++;
    if ({obs_nc, obs_mute, obs_busy} !== 3'b011) begin
      failures++;
      $display("FAIL drop_in_gap got nc/mute/busy=%b%b%b exp=011", obs_nc, obs_mute, obs_busy);
    end
    tick_cycle(0, 0, 4'd3, 2'b00);
    checks++;
    if ({obs_nc, obs_mute, obs_busy} !== 3'b010) begin
      failures++;
      $display("FAIL drop_idle got nc/mute/busy=%b%b%b exp=010", obs_nc, obs_mute, obs_busy);
    end
    start = cyc;
    pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick_cycle(1, 0, 4'd3, 2'b00);
      checks++;
      if ({obs_nc, obs_mute, obs_busy} !== {exp_nc, exp_mute, exp_busy}) begin
        failures++;
        $display("FAIL drop_resume cyc=%0d got=%b%b%b exp=%b%b%b", obs_cyc,
                 obs_nc, obs_mute, obs_busy, exp_nc, exp_mute, exp_busy);
      end
      if (obs_nc && pulse_at < 0) pulse_at = obs_cyc;
    end
    checks++;
    if (pulse_at - start !== 3 + 12) begin
      failures++;
      $display("FAIL drop_resume_latency got=%0d exp=15", pulse_at - start);
    end
    go_idle();
  endtask

`ifdef NOTE_TIMER_TEMPO_EN
  task automatic test_tempo();
    run_fixed("tempo01", 4'd3, 2'b01, 30, 6, 9);
    run_fixed("tempo11", 4'd3, 2'b11, 110, 48, 51);
  endtask
`endif

  task automatic test_random();
    logic [3:0] len;
    logic [1:0] tp;
    bit en, r;
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 59) != 0);
      r   = ($urandom_range(0, 299) == 0);
      len = 4'($urandom_range(0, 15));
`ifdef NOTE_TIMER_TEMPO_EN
      tp  = 2'($urandom_range(0, 3));
`else
      tp  = 2'b00;
`endif
      tick_cycle(en, r, len, tp);
      checks++;
      if ({obs_nc, obs_mute, obs_busy} !== {exp_nc, exp_mute, exp_busy}) begin
        failures++;
        $display("FAIL random cyc=%0d got nc/mute/busy=%b%b%b exp=%b%b%b", obs_cyc,
                 obs_nc, obs_mute, obs_busy, exp_nc, exp_mute, exp_busy);
      end
    end
    go_idle();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; length = 4'd0; tempo = 2'b00;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_zero_length();
    test_no_gap();
    test_enable_drop();
`ifdef NOTE_TIMER_TEMPO_EN
    test_tempo();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
